// File: rtl/burst_grant_pkg.sv
`default_nettype none
// ============================================================================
// Module      : burst_grant_pkg
// Description : Shared types and helpers for the burst grant arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package burst_grant_pkg;

  // Two-state burst controller encoding.
  typedef enum logic [0:0] {
    SM_IDLE   = 1'b0,
    SM_ACTIVE = 1'b1
  } state_t;

  // Decodes a burst-length field of field_w bits: zero means 2**field_w beats,
  // any other value is the beat count itself. Callers zero-extend the field
  // into the 32-bit argument and cast the result back to their own width.
  function automatic logic [31:0] decode_len(input logic [31:0] field,
                                             input int          field_w);
    return (field == 32'd0) ? (32'd1 << field_w) : field;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker. Searches req starting at ptr
//               and wrapping at NUM_CH; returns a one-hot grant and its index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  idx
);

  // First requester at or above ptr wins; the candidate index wraps without a
  // modulo so NUM_CH need not be a power of two.
  always_comb begin
    int   cand;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int off = 0; off < NUM_CH; off++) begin
      cand = int'(ptr) + off;
      if (cand >= NUM_CH) begin
        cand = cand - NUM_CH;
      end
      if (!found && req[IDX_W'(cand)]) begin
        found               = 1'b1;
        grant[IDX_W'(cand)] = 1'b1;
        idx                 = IDX_W'(cand);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/burst_grant_arb.sv
`default_nettype none
// ============================================================================
// Module      : burst_grant_arb
// Description : Round-robin burst grant generator. Accepts one requester per
//               idle cycle and issues a burst of grant beats paced by ready.
// Revision    : 1.0 - initial release
// ============================================================================
module burst_grant_arb
  import burst_grant_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       req,
  input  logic [NUM_CH*CNT_W-1:0] num_grants,
  input  logic                    ready,
  output logic [NUM_CH-1:0]       gnt,
  output logic [NUM_CH-1:0]       req_ack,
  output logic                    last,
  output logic                    busy
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int REM_W = CNT_W + 1;   // holds 2**CNT_W beats

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [REM_W-1:0]   remaining_q, remaining_d;
  logic               first_q, first_d;

  logic [NUM_CH-1:0]  w_arb_grant;
  logic [IDX_W-1:0]   w_arb_idx;
  logic               w_any_req;
  logic [CNT_W-1:0]   w_len_field [NUM_CH];
  logic [NUM_CH-1:0]  w_owner_onehot;

  // Split the packed length bus into one field per channel.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_len_field
      assign w_len_field[gi] = num_grants[gi*CNT_W +: CNT_W];
    end
  endgenerate

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_rr_arbiter (
    .req   (req),
    .ptr   (rr_ptr_q),
    .grant (w_arb_grant),
    .idx   (w_arb_idx)
  );

  assign w_any_req = |w_arb_grant;

  // Next-state logic: accept a winner in idle, count beats while active.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    remaining_d = remaining_q;
    first_d     = 1'b0;
    case (state_q)
      SM_IDLE: begin
        if (w_any_req) begin
          state_d     = SM_ACTIVE;
          owner_d     = w_arb_idx;
          remaining_d = REM_W'(decode_len(32'(w_len_field[w_arb_idx]), CNT_W));
          first_d     = 1'b1;
        end
      end
      SM_ACTIVE: begin
        if (ready) begin
          if (remaining_q == REM_W'(1)) begin
            // Final beat consumed; the pointer moves past the owner so a
            // channel that keeps requesting cannot starve the others.
            state_d  = SM_IDLE;
            rr_ptr_d = (owner_q == IDX_W'(NUM_CH - 1)) ? '0 : owner_q + IDX_W'(1);
          end else begin
            remaining_d = remaining_q - REM_W'(1);
          end
        end
      end
      default: state_d = SM_IDLE;
    endcase
  end

  // State registers with synchronous reset; a reset drops any burst in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SM_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      remaining_q <= '0;
      first_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      remaining_q <= remaining_d;
      first_q     <= first_d;
    end
  end

  // Outputs are decoded purely from registers.
  assign w_owner_onehot = NUM_CH'(1) << owner_q;
  assign busy           = (state_q == SM_ACTIVE);
  assign gnt            = busy ? w_owner_onehot : '0;
  assign req_ack        = (busy && first_q) ? w_owner_onehot : '0;
  assign last           = busy && (remaining_q == REM_W'(1));

endmodule
`default_nettype wire

// File: tb/tb_burst_grant_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_burst_grant_arb
// Description : Scoreboard bench for burst_grant_arb. A behavioural model
//               predicts the outputs after every edge; a monitor compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_burst_grant_arb;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 3;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NUM_CH-1:0]       req;
  logic [NUM_CH*CNT_W-1:0] num_grants;
  logic                    ready;
  logic [NUM_CH-1:0]       gnt;
  logic [NUM_CH-1:0]       req_ack;
  logic                    last;
  logic                    busy;

  typedef struct packed {
    logic [NUM_CH-1:0] gnt;
    logic [NUM_CH-1:0] ack;
    logic              last;
    logic              busy;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   errors  = 0;
  int   cycle   = 0;

  burst_grant_arb #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .num_grants (num_grants),
    .ready      (ready),
    .gnt        (gnt),
    .req_ack    (req_ack),
    .last       (last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference model: a burst is an owner plus a count of beats still owed.
  // After each edge the expected outputs are pushed for the monitor.
  initial begin
    bit in_burst  = 0;
    bit first     = 0;
    int owner     = 0;
    int beats     = 0;
    int ptr       = 0;
    forever begin
      exp_t e;
      @(posedge clk);
      cycle++;
      if (reset) begin
        in_burst = 0; first = 0; ptr = 0; beats = 0;
      end else if (!in_burst) begin
        for (int k = 0; k < NUM_CH; k++) begin
          int c;
          c = (ptr + k) % NUM_CH;
          if (!in_burst && req[c]) begin
            int f;
            f        = int'(num_grants[c*CNT_W +: CNT_W]);
            in_burst = 1;
            first    = 1;
            owner    = c;
            beats    = (f == 0) ? (1 << CNT_W) : f;
          end
        end
      end else begin
        first = 0;
        if (ready) begin
          beats--;
          if (beats == 0) begin
            in_burst = 0;
            ptr      = (owner + 1) % NUM_CH;
          end
        end
      end
      e.gnt  = in_burst ? NUM_CH'(1 << owner) : '0;
      e.ack  = (in_burst && first) ? NUM_CH'(1 << owner) : '0;
      e.last = in_burst && (beats == 1);
      e.busy = in_burst;
      exp_q.push_back(e);
    end
  end

  // Monitor: compares DUT outputs mid-cycle against the oldest prediction.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        vectors++;
        if (gnt !== e.gnt || req_ack !== e.ack || last !== e.last || busy !== e.busy) begin
          errors++;
          $display("FAIL outputs cycle %0d: got gnt=%b req_ack=%b last=%b busy=%b, expected gnt=%b req_ack=%b last=%b busy=%b",
                   cycle, gnt, req_ack, last, busy, e.gnt, e.ack, e.last, e.busy);
        end
      end
    end
  end

  function automatic logic [NUM_CH*CNT_W-1:0] ng4(input int a0, input int a1,
                                                  input int a2, input int a3);
    return {3'(a3), 3'(a2), 3'(a1), 3'(a0)};
  endfunction

  // Applies one input vector for n cycles; values change 1 time unit after an edge.
  task automatic drive(input logic [NUM_CH-1:0] r, input logic [NUM_CH*CNT_W-1:0] ng,
                       input logic rd, input logic rs, input int n);
    for (int i = 0; i < n; i++) begin
      req = r; num_grants = ng; ready = rd; reset = rs;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    req = '0; num_grants = '0; ready = 1'b0; reset = 1'b1;
    drive('0, '0, 1'b0, 1'b1, 2);

    // Single burst: channel 2, length 3.
    drive(4'b0100, ng4(1, 1, 3, 1), 1'b1, 1'b0, 1);
    drive(4'b0000, ng4(1, 1, 5, 1), 1'b1, 1'b0, 5);

    // Zero encoding: channel 0, eight beats.
    drive(4'b0001, ng4(0, 1, 1, 1), 1'b1, 1'b0, 1);
    drive(4'b0000, ng4(2, 2, 2, 2), 1'b1, 1'b0, 10);

    // Backpressure: length 2 with ready 1,0,0,1.
    drive(4'b0010, ng4(1, 2, 1, 1), 1'b1, 1'b0, 1);
    drive(4'b0000, ng4(1, 2, 1, 1), 1'b1, 1'b0, 1);
    drive(4'b0000, ng4(1, 2, 1, 1), 1'b0, 1'b0, 2);
    drive(4'b0000, ng4(1, 2, 1, 1), 1'b1, 1'b0, 3);

    // Round-robin fairness: everyone requesting, length 1.
    drive(4'b1111, ng4(1, 1, 1, 1), 1'b1, 1'b0, 12);
    drive(4'b0000, ng4(1, 1, 1, 1), 1'b1, 1'b0, 2);

    // Wrap and skip: channel 2 burst, then channels 0 and 1.
    drive(4'b0100, ng4(1, 1, 1, 1), 1'b1, 1'b0, 1);
    drive(4'b0000, ng4(1, 1, 1, 1), 1'b1, 1'b0, 2);
    drive(4'b0011, ng4(1, 1, 1, 1), 1'b1, 1'b0, 6);
    drive(4'b0000, ng4(1, 1, 1, 1), 1'b1, 1'b0, 2);

    // Reset mid-burst: length 5, reset after beat 2, then all request.
    drive(4'b0001, ng4(5, 1, 1, 1), 1'b1, 1'b0, 1);
    drive(4'b0000, ng4(5, 1, 1, 1), 1'b1, 1'b0, 2);
    drive(4'b0000, ng4(5, 1, 1, 1), 1'b1, 1'b1, 1);
    drive(4'b1111, ng4(1, 1, 1, 1), 1'b1, 1'b0, 6);

    // Randomized traffic with mid-burst input changes and rare resets.
    for (int i = 0; i < 3000; i++) begin
      logic [NUM_CH-1:0] r;
      r = ($urandom_range(0, 3) == 0) ? '0 : NUM_CH'($urandom_range(0, 15));
      drive(r, (NUM_CH*CNT_W)'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 199) == 0), 1);
    end

    drive('0, '0, 1'b1, 1'b0, 12);
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() > 1) begin
      errors++;
      $display("FAIL scoreboard drain: %0d predictions left, expected at most 1", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
